// File: rtl/adc_capture_window.sv
// adc_capture_window: pre/post-trigger capture controller between the ADC input registers and the FIFO write port
// Ports:
//   Clock, Reset      ADC word clock, asynchronous active-high reset
//   DataIn[31:0]      ADC word {DQD, DQ, DID, DI}, four 8-bit lanes
//   threshold[7:0]    unsigned level; a lane hits when its sample < threshold
//   postCount         post-trigger word count, latched at the trigger
//   arm, abort        start a capture sequence / return to IDLE
//   forceTrigger      trigger pulse honoured while ARMED
//   fifoFull          FIFO cannot accept a write this cycle
//   DataOut[31:0]     word delayed by 2^PRE_LOG2 edges
//   WriteStrobe       FIFO write enable
//   triggered         one-cycle pulse when a trigger is accepted
//   overflow          sticky: a word was dropped because the FIFO was full
//   State[1:0]        0 IDLE, 1 FILL, 2 ARMED, 3 CAPTURE
// Option: define ADC_CAPTURE_REARM_EN to return to ARMED after each record for continuous capture.
module adc_capture_window #(
    parameter int PRE_LOG2 = 4,
    parameter int POST_W   = 12
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       DataIn,
    input  logic [7:0]        threshold,
    input  logic [POST_W-1:0] postCount,
    input  logic              arm,
    input  logic              abort,
    input  logic              forceTrigger,
    input  logic              fifoFull,
    output logic [31:0]       DataOut,
    output logic              WriteStrobe,
    output logic              triggered,
    output logic              overflow,
    output logic [1:0]        State
);
    localparam int DEPTH = 1 << PRE_LOG2;
    localparam logic [POST_W:0] LAST = (POST_W + 1)'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, ARMED = 2'd2, CAPTURE = 2'd3} state_t;

`ifdef ADC_CAPTURE_REARM_EN
    localparam state_t DONE = ARMED;
`else
    localparam state_t DONE = IDLE;
`endif

    state_t              state;
    logic [31:0]         dl [DEPTH];
    logic [PRE_LOG2-1:0] fill_cnt;
    logic [POST_W:0]     wr_cnt;
    logic [POST_W:0]     wr_len;
    logic                level_hit;

    assign level_hit = (DataIn[31:24] < threshold) || (DataIn[23:16] < threshold) ||
                       (DataIn[15:8] < threshold) || (DataIn[7:0] < threshold);
    // One extra bit keeps 2^PRE_LOG2 + max postCount from wrapping.
    assign wr_len = (POST_W + 1)'(DEPTH) + {1'b0, postCount};
    // Combinational so a full FIFO drops the word in the same cycle and reset kills the strobe at once.
    assign WriteStrobe = (state == CAPTURE) && !fifoFull;
    assign State = state;

    // History is never strobed out before FILL has refreshed it, so it needs no reset.
    always_ff @(posedge Clock) begin
        dl[0] <= DataIn;
        for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            DataOut   <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
            fill_cnt  <= '0;
            wr_cnt    <= '0;
        end else begin
            DataOut   <= dl[DEPTH-1];
            triggered <= 1'b0;
            if (state == CAPTURE && fifoFull) overflow <= 1'b1;
            if (abort) state <= IDLE;
            else case (state)
                IDLE: if (arm) begin
                    state    <= FILL;
                    overflow <= 1'b0;
                    fill_cnt <= '0;
                end
                FILL: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (&fill_cnt) state <= ARMED;
                end
                ARMED: if (level_hit || forceTrigger) begin
                    state     <= CAPTURE;
                    triggered <= 1'b1;
                    wr_cnt    <= wr_len;
                end
                CAPTURE: begin
                    wr_cnt <= wr_cnt - 1'b1;
                    if (wr_cnt == LAST) state <= DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_capture_window.sv
// tb_adc_capture_window: randomized self-checking bench with a record-level reference model
module tb_adc_capture_window;
    localparam int D = 16;
`ifdef ADC_CAPTURE_REARM_EN
    localparam bit REARM = 1'b1;
`else
    localparam bit REARM = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] DataIn = '0;
    logic [7:0]  threshold = '0;
    logic [11:0] postCount = '0;
    logic        arm = 1'b0, abort = 1'b0, forceTrigger = 1'b0, fifoFull = 1'b0;
    logic [31:0] DataOut;
    logic        WriteStrobe, triggered, overflow;
    logic [1:0]  State;

    int n_cmp = 0, n_bad = 0, trig_n = 0;
    logic [31:0] hist[$], got[$], exp_q[$];
    bit forceh[$], fullh[$];

    adc_capture_window #(.PRE_LOG2(4), .POST_W(12)) dut (
        .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .threshold(threshold),
        .postCount(postCount), .arm(arm), .abort(abort), .forceTrigger(forceTrigger),
        .fifoFull(fifoFull), .DataOut(DataOut), .WriteStrobe(WriteStrobe),
        .triggered(triggered), .overflow(overflow), .State(State)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (WriteStrobe === 1'b1) got.push_back(DataOut);
        if (triggered === 1'b1) trig_n++;
    end

    task automatic step(input logic [31:0] d, input logic a = 0, input logic ab = 0,
                        input logic f = 0, input logic ff = 0);
        DataIn = d; arm = a; abort = ab; forceTrigger = f; fifoFull = ff;
        @(posedge Clock);
        hist.push_back(d); forceh.push_back(f); fullh.push_back(ff);
        #1;
    endtask

    function automatic logic [31:0] rep(input int n);
        logic [7:0] b = 8'(n);
        return {4{b}};
    endfunction

    function automatic logic [31:0] safe_word();
        return {8'($urandom_range(255, 64)), 8'($urandom_range(255, 64)),
                8'($urandom_range(255, 64)), 8'($urandom_range(255, 64))};
    endfunction

    function automatic bit hit(input logic [31:0] w);
        return (w[31:24] < threshold) || (w[23:16] < threshold) || (w[15:8] < threshold) || (w[7:0] < threshold);
    endfunction

    // First edge at or after 'from' where a trigger condition was presented.
    function automatic int model_trig(input int from);
        for (int e = from; e < hist.size(); e++) if (forceh[e] || hit(hist[e])) return e;
        return -1;
    endfunction

    // A record triggered at edge t0 holds the words from t0-D on; words presented while full are lost.
    task automatic model_record(input int t0, input int post);
        for (int k = 0; k < D + post; k++) if (!fullh[t0 + k + 1]) exp_q.push_back(hist[t0 - D + k]);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) step($urandom);
        n_cmp++; if (State !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", State); end
        n_cmp++; if (DataOut !== 32'h0) begin n_bad++; $display("FAIL reset_dataout: got %h want 0", DataOut); end
        n_cmp++; if (WriteStrobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", WriteStrobe); end
        n_cmp++; if (triggered !== 1'b0) begin n_bad++; $display("FAIL reset_triggered: got %b want 0", triggered); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        Reset = 1'b0;
        repeat (20) step($urandom, 0, 0, 1, 0);
        n_cmp++; if (State !== 2'd0) begin n_bad++; $display("FAIL idle_ignores_force: got %0d want 0", State); end
    endtask

    task automatic test_ramp();
        int a, t0;
        threshold = 8'h00; postCount = 12'd8;
        got.delete(); exp_q.delete(); trig_n = 0;
        a = hist.size();
        for (int n = 0; n <= 130; n++) begin
            step(rep(n), n == 0, 0, n == 100, 0);
            if (n == 15 || n == 16 || n == 100 || n == 123 || n == 124) begin
                logic [1:0] ws;
                ws = n == 15 ? 2'd1 : n == 16 ? 2'd2 : (n == 100 || n == 123) ? 2'd3 : (REARM ? 2'd2 : 2'd0);
                n_cmp++; if (State !== ws) begin n_bad++; $display("FAIL ramp_state@%0d: got %0d want %0d", n, State, ws); end
            end
            if (n == 100) begin
                n_cmp++; if (triggered !== 1'b1) begin n_bad++; $display("FAIL ramp_trig_pulse: got %b want 1", triggered); end
            end
            if (n == 124) begin
                n_cmp++; if (WriteStrobe !== 1'b0) begin n_bad++; $display("FAIL ramp_strobe_end: got %b want 0", WriteStrobe); end
            end
        end
        t0 = model_trig(a + D + 1);
        model_record(t0, 8);
        n_cmp++; if (got.size() != 24) begin n_bad++; $display("FAIL ramp_count: got %0d want 24", got.size()); end
        if (got.size() > 16) begin
            n_cmp++; if (got[0] !== rep(84)) begin n_bad++; $display("FAIL ramp_first: got %h want %h", got[0], rep(84)); end
            n_cmp++; if (got[16] !== rep(100)) begin n_bad++; $display("FAIL ramp_trigword: got %h want %h", got[16], rep(100)); end
        end
        foreach (exp_q[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL ramp_word[%0d]: got %h want %h", k, got[k], exp_q[k]); end
        end
        n_cmp++; if (trig_n != 1) begin n_bad++; $display("FAIL ramp_trig_count: got %0d want 1", trig_n); end
        step($urandom, 0, 1);
    endtask

    task automatic test_level();
        int a, t0, post, r;
        threshold = 8'h40; post = $urandom_range(20, 1); postCount = 12'(post); r = $urandom_range(10, 1);
        got.delete(); exp_q.delete(); trig_n = 0;
        a = hist.size();
        step(safe_word(), 1);
        for (int j = 1; j <= D + r; j++) step(safe_word());
        step(32'h3F808080);
        for (int j = 0; j < D + post + 5; j++) step(safe_word());
        t0 = model_trig(a + D + 1);
        model_record(t0, post);
        n_cmp++; if (got.size() != D + post) begin n_bad++; $display("FAIL level_count: got %0d want %0d", got.size(), D + post); end
        foreach (exp_q[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL level_word[%0d]: got %h want %h", k, got[k], exp_q[k]); end
        end
        n_cmp++; if (trig_n != 1) begin n_bad++; $display("FAIL level_trig_count: got %0d want 1", trig_n); end
        n_cmp++; if (State !== (REARM ? 2'd2 : 2'd0)) begin n_bad++; $display("FAIL level_end_state: got %0d want %0d", State, REARM ? 2 : 0); end
        step($urandom, 0, 1);
    endtask

    task automatic test_fill_ignore();
        int a, t0, post;
        threshold = 8'h00; post = $urandom_range(15, 0); postCount = 12'(post);
        got.delete(); exp_q.delete(); trig_n = 0;
        a = hist.size();
        for (int j = 0; j <= D + post + 22; j++) begin
            step($urandom, j == 0, 0, j == 3 || j == 16 || j == 17, 0);
            if (j == 3) begin
                n_cmp++; if (triggered !== 1'b0 || State !== 2'd1) begin
                    n_bad++; $display("FAIL fill_ignore: got trig=%b state=%0d want trig=0 state=1", triggered, State);
                end
            end
        end
        t0 = model_trig(a + D + 1);
        model_record(t0, post);
        n_cmp++; if (got.size() != D + post) begin n_bad++; $display("FAIL fill_count: got %0d want %0d", got.size(), D + post); end
        foreach (exp_q[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL fill_word[%0d]: got %h want %h", k, got[k], exp_q[k]); end
        end
        n_cmp++; if (trig_n != 1) begin n_bad++; $display("FAIL fill_trig_count: got %0d want 1", trig_n); end
        step($urandom, 0, 1);
    endtask

    task automatic test_overflow();
        int a, t0;
        threshold = 8'h00; postCount = 12'd10;
        got.delete(); exp_q.delete(); trig_n = 0;
        a = hist.size();
        for (int j = 0; j <= 51; j++) begin
            step($urandom, j == 0, 0, j == 20, j >= 29 && j <= 33);
            if (j == 0) begin
                n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_start: got %b want 0", overflow); end
            end
        end
        t0 = model_trig(a + D + 1);
        model_record(t0, 10);
        n_cmp++; if (got.size() != 21) begin n_bad++; $display("FAIL ovf_count: got %0d want 21", got.size()); end
        foreach (exp_q[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL ovf_word[%0d]: got %h want %h", k, got[k], exp_q[k]); end
        end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        step($urandom, 0, 1);
        n_cmp++; if (overflow !== 1'b1 || State !== 2'd0) begin
            n_bad++; $display("FAIL ovf_abort_hold: got ovf=%b state=%0d want ovf=1 state=0", overflow, State);
        end
        step($urandom, 1);
        n_cmp++; if (overflow !== 1'b0 || State !== 2'd1) begin
            n_bad++; $display("FAIL ovf_arm_clear: got ovf=%b state=%0d want ovf=0 state=1", overflow, State);
        end
        step($urandom, 0, 1);
    endtask

    task automatic test_abort();
        int a, t0, post;
        threshold = 8'h00; post = $urandom_range(30, 10); postCount = 12'(post);
        got.delete(); exp_q.delete(); trig_n = 0;
        a = hist.size();
        for (int j = 0; j <= 40; j++) begin
            step($urandom, j == 0 || j == 28, j == 28, j == 20, 0);
            if (j == 28) begin
                n_cmp++; if (State !== 2'd0 || WriteStrobe !== 1'b0) begin
                    n_bad++; $display("FAIL abort_now: got state=%0d strobe=%b want state=0 strobe=0", State, WriteStrobe);
                end
            end
        end
        t0 = model_trig(a + D + 1);
        for (int k = 0; k < 8; k++) exp_q.push_back(hist[t0 - D + k]);
        n_cmp++; if (State !== 2'd0) begin n_bad++; $display("FAIL abort_arm_ignored: got %0d want 0", State); end
        n_cmp++; if (got.size() != 8) begin n_bad++; $display("FAIL abort_count: got %0d want 8", got.size()); end
        foreach (exp_q[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL abort_word[%0d]: got %h want %h", k, got[k], exp_q[k]); end
        end
        n_cmp++; if (trig_n != 1) begin n_bad++; $display("FAIL abort_trig_count: got %0d want 1", trig_n); end
        for (int j = 0; j <= 24; j++) step($urandom, j == 0, 0, j == 18, 0);
        n_cmp++; if (WriteStrobe !== 1'b1 || State !== 2'd3) begin
            n_bad++; $display("FAIL rst_precheck: got strobe=%b state=%0d want strobe=1 state=3", WriteStrobe, State);
        end
        #1 Reset = 1'b1;
        #1;
        n_cmp++; if (WriteStrobe !== 1'b0 || State !== 2'd0 || DataOut !== 32'h0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL rst_async: got strobe=%b state=%0d data=%h ovf=%b want 0/0/0/0", WriteStrobe, State, DataOut, overflow);
        end
        step($urandom);
        Reset = 1'b0;
        step($urandom);
    endtask

    task automatic test_back_to_back();
        int a, t, recs;
        threshold = 8'h40; postCount = 12'd0;
        got.delete(); exp_q.delete(); trig_n = 0;
        a = hist.size();
        for (int j = 0; j <= 84; j++) begin
            step($urandom & 32'h3F3F3F3F, j == 0, j == 84, 0, 0);
            if (j == 32 || j == 33 || j == 34) begin
                logic [1:0] ws;
                ws = j == 32 ? 2'd3 : j == 33 ? (REARM ? 2'd2 : 2'd0) : (REARM ? 2'd3 : 2'd0);
                n_cmp++; if (State !== ws) begin n_bad++; $display("FAIL b2b_state@%0d: got %0d want %0d", j, State, ws); end
            end
        end
        recs = 0;
        t = model_trig(a + D + 1);
        while (t >= 0 && (REARM || recs == 0)) begin
            model_record(t, 0);
            recs++;
            t = model_trig(t + D + 1);
        end
        n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", got.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < got.size()) begin
            n_cmp++; if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL b2b_word[%0d]: got %h want %h", k, got[k], exp_q[k]); end
        end
        n_cmp++; if (trig_n != recs) begin n_bad++; $display("FAIL b2b_trig_count: got %0d want %0d", trig_n, recs); end
        n_cmp++; if (State !== 2'd0) begin n_bad++; $display("FAIL b2b_end_state: got %0d want 0", State); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_level();
        test_fill_ignore();
        test_overflow();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_capture_window.md
Name: adc_capture_window

Overview:
- Pre/post-trigger capture controller between the ADC data input registers (32-bit word, four 8-bit samples per ADC clock) and the data storage FIFO write port.
- Keeps a rolling pre-trigger history of 2^PRE_LOG2 words and detects a level trigger on any of the four lanes, or accepts a forced trigger.
- On a trigger it emits the write strobe for exactly 2^PRE_LOG2 + postCount words, so stored records contain data from before and after the event.
- Runs entirely in the ADC clock domain.

Parameters:
- PRE_LOG2, 4: log2 of the pre-trigger depth in words (default 16 words).
- POST_W, 12: width of the postCount input and of the post-trigger counter.

Ports:
- Clock  in  1  ADC word clock; all logic is on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- DataIn  in  32  ADC word {DQD[31:24], DQ[23:16], DID[15:8], DI[7:0]}.
- threshold  in  8  unsigned trigger level; a lane triggers when its sample < threshold.
- postCount  in  POST_W  number of post-trigger words; latched at the trigger.
- arm  in  1  single-cycle pulse that starts a capture sequence.
- abort  in  1  single-cycle pulse that returns the block to IDLE immediately.
- forceTrigger  in  1  single-cycle pulse; acts as a trigger while ARMED.
- fifoFull  in  1  high when the FIFO cannot accept a write.
- DataOut  out  32  delayed data to the FIFO.
- WriteStrobe  out  1  FIFO write enable.
- triggered  out  1  single-cycle pulse on the cycle the trigger is accepted.
- overflow  out  1  sticky flag: one or more words were dropped because fifoFull was high.
- State  out  2  0 = IDLE, 1 = FILL, 2 = ARMED, 3 = CAPTURE.

Behaviour:
- Reset values: State = IDLE, DataOut = 0, WriteStrobe = 0, triggered = 0, overflow = 0, all counters 0. Delay-line contents are undefined after reset; the FILL state guarantees they are never strobed out.
- Delay line:
  - Shifts every cycle in every state.
  - DataOut is registered and, in any cycle, equals the DataIn sampled 2^PRE_LOG2 edges earlier.
- Level trigger: levelHit = OR over the four lanes of (lane < threshold), compared unsigned. threshold = 0 means the level trigger can never fire.
- IDLE:
  - arm -> FILL. On that edge, clear overflow and clear the fill counter.
  - forceTrigger and levelHit are ignored.
- FILL:
  - The fill counter increments every cycle.
  - When 2^PRE_LOG2 words have been shifted in since arm -> ARMED.
  - Triggers are ignored in this state.
- ARMED:
  - (levelHit | forceTrigger) -> CAPTURE on the next edge.
  - On that edge: triggered = 1 for one cycle, postCount is latched, and the write counter is loaded with 2^PRE_LOG2 + postCount.
- CAPTURE:
  - WriteStrobe = ~fifoFull for each of exactly 2^PRE_LOG2 + postCount consecutive cycles, starting in the first cycle of CAPTURE.
  - Word 0 is the DataIn sampled 2^PRE_LOG2 cycles before the trigger word. The trigger word is word index 2^PRE_LOG2.
  - The write counter decrements every cycle whether or not fifoFull is high; a dropped word is not retried.
  - Any cycle with fifoFull high sets overflow.
  - On the last word -> IDLE, and WriteStrobe is 0 on the following cycle.
- postCount = 0: only the 2^PRE_LOG2 pre-trigger words are written.
- postCount at its maximum (all ones): the counter is sized POST_W+1 bits, so no wrap occurs.
- abort in any state: -> IDLE on the next edge and WriteStrobe = 0 that cycle. overflow holds its value. abort has priority over arm and over triggers in the same cycle.
- arm outside IDLE is ignored.
- Level trigger and forceTrigger in the same cycle count as a single trigger.
- Asynchronous Reset mid-CAPTURE: WriteStrobe drops immediately (without a clock edge) and State = IDLE.

Optional Feature:
- Macro: ADC_CAPTURE_REARM_EN.
- When defined: CAPTURE completion -> ARMED instead of IDLE, which gives continuous multi-record capture. The delay line is already full, so FILL is skipped. A new trigger is accepted starting the cycle after the last strobed word. Only abort or Reset returns the block to IDLE. overflow is cleared only by arm.
- When undefined: one-shot behaviour, as described under Behaviour.

Test Plan:
- Ramp DataIn with all lanes = n (mod 256), threshold = 0, forceTrigger on word 100 after arm: expect exactly 16 + postCount (postCount = 8) = 24 strobes; first DataOut lanes = 84, trigger word 100 at index 16; State returns to 0.
- threshold = 0x40, DQD lane drops to 0x3F while the other lanes sit at 0x80, in ARMED: triggered pulses once; the record holds 16 + postCount words.
- Trigger in FILL (3 cycles after arm): ignored; the next trigger after 16 fill cycles is accepted.
- fifoFull high for 5 cycles mid-CAPTURE, postCount = 10: 26 - 5 = 21 strobes; overflow = 1 until the next arm clears it.
- abort during CAPTURE at word 7 together with arm: WriteStrobe is 0 from the next cycle, State = IDLE, arm is ignored. Reset asserted mid-capture clears all outputs asynchronously.
- With ADC_CAPTURE_REARM_EN, level held below threshold, postCount = 0: back-to-back 16-word records with State cycling 3 -> 2 -> 3 and one triggered pulse per record.
